// File: rtl/tru4bit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module : tru4bit_serial_pkg
// Brief  : Shared definitions for the bit-serial subtractor (tru_defs):
//          FSM state encoding and the iteration-counter width helper.
// Rev    : 1.0  initial release
// ============================================================================
package tru4bit_serial_pkg;

  // Controller states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH itself (the value after the last bit).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tru4bit_serial_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module : full_subtractor
// Brief  : 1-bit combinational full subtractor, d = a - b - bin.
// Rev    : 1.0  initial release
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out (borrow when a < b + bin).
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/tru4bit_serial.sv
`default_nettype none
// ============================================================================
// Module : tru4bit_serial
// Brief  : Bit-serial WIDTH-bit subtractor, Diff = A - B - Bin, LSB first,
//          one bit per clock with a start/busy/done handshake. Results stay
//          registered until the next operation completes.
// Rev    : 1.0  initial release
// ============================================================================
module tru4bit_serial
  import tru4bit_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int            CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Only WIDTH-1 bits are kept: the final bit goes straight into Diff, so the
  // oldest slot would never hold anything useful.
  logic [WIDTH-2:0] r_res_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_full;

  // Operands are only captured from IDLE or DONE; start during SHIFT is ignored.
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_count == C_LAST);
  assign w_res_full = {w_d, r_res_sr};

  full_subtractor u_fsub (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? SHIFT : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Serial datapath; result registers load on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      Diff     <= '0;
      Bout     <= 1'b0;
      Ovf      <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= A;
      r_b_sr   <= B;
      r_borrow <= Bin;
      r_count  <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_full[WIDTH-1:1];
      r_borrow <= w_bout;
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        Diff <= w_res_full;
        Bout <= w_bout;
        // Signed overflow: borrow into the MSB differs from borrow out of it.
        Ovf  <= r_borrow ^ w_bout;
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_tru4bit_serial.sv
`default_nettype none
// ============================================================================
// Module : tb_tru4bit_serial
// Brief  : Self-checking bench for tru4bit_serial (WIDTH=4): directed cases
//          with literal expectations plus an arithmetic reference model
//          compared against the outputs every cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tru4bit_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [3:0] Diff;
  logic       Bout;
  logic       Ovf;

  int n_checks = 0;
  int n_fail   = 0;

  tru4bit_serial #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {diff[3:0], bout, ovf}.
  function automatic logic [5:0] golden(input int a, input int b, input int bi);
    int u, sa, sb, s;
    logic [3:0] d;
    u  = a - b - bi;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    s  = sa - sb - bi;
    d  = u[3:0];
    return {d, (u < 0), ((s < -8) || (s > 7))};
  endfunction

  // ---------------- reference model (timing + values) ----------------
  typedef struct {
    logic [3:0] d;
    logic       bo;
    logic       ov;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         cyc        = 0;
  int         busy_until = 0;
  logic [3:0] h_d  = '0;
  logic       h_bo = 1'b0;
  logic       h_ov = 1'b0;
  bit         prev_done = 1'b0;
  bit         e_done, e_busy;

  // An accepted request yields its result WIDTH edges later; the next request
  // can be taken WIDTH+1 edges after the previous acceptance.
  always @(posedge clk) begin
    logic [5:0] g;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      busy_until = 0;
      h_d = '0; h_bo = 1'b0; h_ov = 1'b0;
    end else if (start && cyc >= busy_until) begin
      g     = golden(A, B, Bin);
      e.d   = g[5:2];
      e.bo  = g[1];
      e.ov  = g[0];
      e.due = cyc + 4;
      q.push_back(e);
      busy_until = cyc + 5;
    end
  end

  // Compare DUT against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      e_done = (q.size() > 0) && (q[0].due == cyc);
      e_busy = (q.size() > 0) && (cyc < q[0].due);
      if (e_done) begin
        h_d  = q[0].d;
        h_bo = q[0].bo;
        h_ov = q[0].ov;
        void'(q.pop_front());
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("diff", Diff, h_d);
      chk("bout", Bout, h_bo);
      chk("ovf", Ovf, h_ov);
      chk("done_width", int'(done && prev_done), 0);
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       output int lat, output int nb);
    @(negedge clk);
    A = a; B = b; Bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
    lat = 1; nb = 0;
    while (!done && lat < 20) begin
      nb += int'(busy);
      @(negedge clk);
      lat++;
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic check_res(input string name, input int d, input int bo, input int ov);
    chk({name, "_diff"}, Diff, d);
    chk({name, "_bout"}, Bout, bo);
    chk({name, "_ovf"},  Ovf,  ov);
  endtask

  initial begin
    int lat, nb, np, gap;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    check_res("reset", 0, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // Pin the reference arithmetic itself.
    chk("model_pin1", golden(3, 5, 0), {4'hE, 1'b1, 1'b0});
    chk("model_pin2", golden(8, 1, 0), {4'h7, 1'b0, 1'b1});

    // 1: basic, with latency and busy length
    do_op(4'd5, 4'd3, 1'b0, lat, nb);
    chk("t1_latency", lat, 5);
    chk("t1_busy_cycles", nb, 4);
    check_res("t1", 2, 0, 0);

    // 2: wrap-around and borrow-in only
    do_op(4'd3, 4'd5, 1'b0, lat, nb);
    check_res("t2a", 4'hE, 1, 0);
    do_op(4'd0, 4'd0, 1'b1, lat, nb);
    check_res("t2b", 4'hF, 1, 0);

    // 3: signed overflow both directions
    do_op(4'd8, 4'd1, 1'b0, lat, nb);
    check_res("t3a", 7, 0, 1);
    do_op(4'd7, 4'hF, 1'b0, lat, nb);
    check_res("t3b", 8, 1, 1);

    // 4: start during SHIFT ignored, operand change has no effect
    @(negedge clk);
    A = 4'd9; B = 4'd2; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 4'd0; B = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("t4_latency", lat, 5);
    check_res("t4", 7, 0, 1);
    np = 0;
    repeat (8) begin @(negedge clk); np += int'(done); end
    chk("t4_extra_done", np, 0);

    // 5: start held high, back-to-back results
    @(negedge clk);
    A = 4'hF; B = 4'hF; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    A = 4'hC; B = 4'h4; Bin = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("t5a_latency", lat, 5);
    check_res("t5a", 4'hF, 1, 0);
    gap = 0;
    @(negedge clk); gap++;
    while (!done && gap < 20) begin @(negedge clk); gap++; end
    chk("t5_period", gap, 5);
    check_res("t5b", 8, 0, 0);
    start = 1'b0;

    // 6: reset two cycles into SHIFT aborts everything
    @(negedge clk);
    A = 4'd6; B = 4'd1; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    check_res("t6", 0, 0, 0);
    rst = 1'b0;
    np = 0;
    repeat (10) begin @(negedge clk); np += int'(done); end
    chk("t6_no_done", np, 0);

    // Exhaustive sweep; values are checked by the model every cycle.
    for (int i = 0; i < 512; i++) begin
      do_op(4'(i >> 5), 4'(i >> 1), 1'(i), lat, nb);
      chk("sweep_latency", lat, 5);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire
